uartin: RTL
===========

UARTIN -- requirements
Module: uartin

Interface
REQ-001 SHALL have parameter CDIV, default 434, meaning clocks per UART bit period (50 MHz / 115200 baud); legal range CDIV >= 4.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  UART serial input, asynchronous to clk, idle high.
REQ-005 SHALL have port n_cs  input  1  downstream FIFO ready, active-low: 0 means the FIFO can accept a byte (driven from ~n_full).
REQ-006 SHALL have port port  output  8  received byte presented to the FIFO write port.
REQ-007 SHALL have port n_wr  output  1  FIFO write strobe, active-low, one clock wide.
REQ-008 SHALL have port frame_err  output  1  one-clock pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-clock pulse: valid byte dropped because n_cs was high.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK with a bit-timing counter cnt that clears on every state change.
REQ-012 IDLE: on rx_s == 0 SHALL go to START with cnt = 0.
REQ-013 START: at cnt == CDIV/2 - 1 (integer floor) SHALL sample rx_s; 1 -> IDLE (glitch rejected, no outputs); 0 -> DATA.
REQ-014 DATA: at each cnt == CDIV - 1 SHALL sample rx_s into a shift register LSB-first; after the 8th sample SHALL go to STOP.
REQ-015 STOP: at cnt == CDIV - 1 SHALL sample rx_s and act per REQ-016..REQ-018.
REQ-016 Stop = 1 and n_cs == 0: SHALL load port with the byte and drive n_wr low for exactly the next clock, then go to IDLE.
REQ-017 Stop = 1 and n_cs == 1: SHALL pulse overrun for one clock, leave port and n_wr unchanged, then go to IDLE.
REQ-018 Stop = 0: SHALL pulse frame_err for one clock, issue no write, then go to BREAK.
REQ-019 BREAK: SHALL stay until rx_s == 1, then go to IDLE, so that a held-low line yields exactly one frame_err.
REQ-020 port SHALL hold its value between writes and change only on the clock n_wr goes low.
REQ-021 n_cs SHALL be sampled only at the stop-bit sample instant; its value at other times SHALL have no effect.
REQ-022 Latency: n_wr SHALL fall between 9*CDIV + CDIV/2 + 1 and 9*CDIV + CDIV/2 + 4 clocks after the rx falling edge of the start bit.
REQ-023 A start bit beginning immediately after a valid stop-bit sample SHALL be received; back-to-back frames with no extra idle SHALL not be lost.
REQ-024 frame_err, overrun and n_wr-low SHALL be mutually exclusive in any clock.
REQ-025 cnt SHALL be wide enough for CDIV - 1 and SHALL never wrap within a state.

Reset
REQ-026 While n_rst == 0 SHALL hold: state IDLE, cnt 0, shift register 0, port 8'h00, n_wr 1, frame_err 0, overrun 0, synchronizer flops 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no write or error pulse; after release the block SHALL wait for a fresh falling edge.

Verification (CDIV = 8 in simulation; n_cs = 0 unless stated)
REQ-028 Send 0x41 (8N1) -> exactly one n_wr low pulse with port = 0x41, within the REQ-022 window; no error pulses.
REQ-029 Drive rx low for 2 clocks, then high -> no n_wr, frame_err or overrun; the next 0x5A frame is received correctly.
REQ-030 Send 0xA5 with stop bit 0, then hold rx low 40 clocks -> exactly one frame_err, no n_wr; after rx returns high, 0x33 is received.
REQ-031 Send 0x7E with n_cs = 1 at the stop sample -> one overrun pulse, n_wr stays 1, port keeps its previous value.
REQ-032 Send 0x00, 0xFF, 0x55 back-to-back with no idle bits -> three n_wr pulses with port = 0x00, 0xFF, 0x55 in order.
REQ-033 Assert n_rst during data bit 4 of a frame -> all outputs at reset values within the same clock; after release a new 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uartin.sv
// UART receiver (8N1) feeding a FIFO write port.
// The rx line is double-flopped, the start bit is validated at mid-bit,
// eight data bits are sampled LSB-first at one-bit spacing, and the stop bit
// decides between a write, an overrun pulse or a frame error.
// A line held low after a frame error parks in BREAK until rx returns high,
// so it produces only one error pulse.
`timescale 1ns/1ps
module uartin #(
    parameter int CDIV = 434
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx,
    input  logic       n_cs,
    output logic [7:0] port,
    output logic       n_wr,
    output logic       frame_err,
    output logic       overrun
);

    // Counter only has to reach CDIV-1, never more.
    localparam int CW = (CDIV > 1) ? $clog2(CDIV) : 1;
    localparam logic [CW-1:0] FULL_LAST = CW'(CDIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CDIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [1:0]    sync_r;
    logic          rx_s;
    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [2:0]    bit_cnt_r;
    logic [2:0]    bit_cnt_s;
    logic [7:0]    shreg_r;
    logic [7:0]    shreg_s;
    logic [7:0]    port_r;
    logic [7:0]    port_s;
    logic          n_wr_r;
    logic          n_wr_s;
    logic          frame_err_r;
    logic          frame_err_s;
    logic          overrun_r;
    logic          overrun_s;

    assign rx_s      = sync_r[1];
    assign port      = port_r;
    assign n_wr      = n_wr_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

    // Two-flop synchronizer for the asynchronous rx line (idles high).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

    // Next-state, bit timing, shift register and output pulse decode.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shreg_s     = shreg_r;
        port_s      = port_r;
        n_wr_s      = 1'b1;
        frame_err_s = 1'b0;
        overrun_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_s     = CNT_ZERO;
                bit_cnt_s = 3'd0;
                if (!rx_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = CNT_ZERO;
                    // High at mid start bit: treat as a glitch.
                    if (rx_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_s     = CNT_ZERO;
                    shreg_s   = {rx_s, shreg_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (rx_s) begin
                        // n_cs only matters at this instant.
                        if (!n_cs) begin
                            port_s = shreg_r;
                            n_wr_s = 1'b0;
                        end else begin
                            overrun_s = 1'b1;
                        end
                        state_s = ST_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = ST_BREAK;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_BREAK: begin
                cnt_s = CNT_ZERO;
                if (rx_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            bit_cnt_r   <= 3'd0;
            shreg_r     <= 8'h00;
            port_r      <= 8'h00;
            n_wr_r      <= 1'b1;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shreg_r     <= shreg_s;
            port_r      <= port_s;
            n_wr_r      <= n_wr_s;
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
        end
    end

endmodule
